coarse_ctrl: RTL and testbench

- Measurement sequencer for the TDC coarse clock counter.
- Arms the counter, clears it, runs it between a start hit and a stop hit, then strobes the hold and captures the held count.
- Presents the result through a valid/ready handshake, with a timeout when no stop hit arrives.
- Sits between the hit synchronisers and the coarse counter; its result feeds the fine/coarse merge stage.

---
 rtl/tdc_pkg.sv | 22 ++
 rtl/tdc_timeout_cnt.sv | 34 +++
 rtl/coarse_ctrl.sv | 108 ++++++++++
 tb/tb_coarse_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared TDC definitions: sequencer state encoding, default coarse width and
// the timeout-counter width helper.
package tdc_pkg;

  localparam int C_DIG_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ARMED   = 3'd2,
    RUN     = 3'd3,
    STORE   = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6
  } ctrlStateT;

  // Bits needed to count 0 .. cyc-1; never narrower than one bit.
  function automatic int tmoCntWidth(input int cyc);
    return (cyc > 2) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/tdc_timeout_cnt.sv
// Cycle counter with synchronous clear and enable; pulses oTc on the enabled
// cycle where the count reaches TIMEOUT_CYC-1.
module tdc_timeout_cnt
  import tdc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic clk,
  input  logic iRst_n,
  input  logic iClear,
  input  logic iEnable,
  output logic oTc
);

  localparam int CW = tmoCntWidth(TIMEOUT_CYC);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (iClear) begin
      cnt <= '0;
    end else if (iEnable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign oTc = iEnable && (cnt == TC_VAL);

endmodule

// File: rtl/coarse_ctrl.sv
// Coarse-counter measurement sequencer: clear, run between start and stop
// hits (or until timeout), hold, capture, then hand off via valid/ready.
module coarse_ctrl
  import tdc_pkg::*;
#(
  parameter int C_DIG       = C_DIG_DEFAULT,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic           clk,
  input  logic           iRst_n,
  input  logic           iArm,
  input  logic           iStart,
  input  logic           iStop,
  input  logic           iAbort,
  input  logic [C_DIG:0] iCoarse,
  input  logic           iReady,
  output logic           oCntRst,
  output logic           oCntCE,
  output logic           oCntStore,
  output logic [C_DIG:0] oResult,
  output logic           oTimeout,
  output logic           oValid,
  output logic           oBusy
);

  ctrlStateT state, nextState;
  logic      abortHit;
  logic      abortRst;
  logic      tmoFlag;
  logic      tmoTc;

  assign abortHit = iAbort && (state != IDLE);

  tdc_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) uTimeout (
    .clk     (clk),
    .iRst_n  (iRst_n),
    .iClear  (abortHit || (state != RUN)),
    .iEnable (state == RUN),
    .oTc     (tmoTc)
  );

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: nextState is defaulted before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (iArm) nextState = CLEAR;
      CLEAR:   nextState = ARMED;
      ARMED:   if (iStart) nextState = RUN;
      RUN:     if (iStop || tmoTc) nextState = STORE;
      STORE:   nextState = CAPTURE;
      CAPTURE: nextState = DONE;
      DONE:    if (oValid && iReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abortHit) nextState = IDLE;
  end

  // Counter controls decode from registered state only; the abort reset pulse
  // is itself a flop so no input reaches these pins combinationally.
  assign oCntRst   = (state == CLEAR) || abortRst;
  assign oCntCE    = (state == RUN);
  assign oCntStore = (state == STORE);
  assign oBusy     = (state != IDLE);

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      abortRst <= 1'b0;
      tmoFlag  <= 1'b0;
      oResult  <= '0;
      oTimeout <= 1'b0;
      oValid   <= 1'b0;
    end else begin
      abortRst <= abortHit;
      if (abortHit) begin
        oValid <= 1'b0;
      end else begin
        unique case (state)
          RUN: begin
            // Stop beats a coincident timeout.
            if (iStop)      tmoFlag <= 1'b0;
            else if (tmoTc) tmoFlag <= 1'b1;
          end
          CAPTURE: begin
            oResult  <= iCoarse;
            oTimeout <= tmoFlag;
            oValid   <= 1'b1;
          end
          DONE: begin
            if (oValid && iReady) oValid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coarse_ctrl.sv
// Directed bench for coarse_ctrl with a behavioural coarse counter and a
// result scoreboard queue.
module tb_coarse_ctrl;

  localparam int C_DIG = 10;
  localparam int TMO   = 100;

  typedef struct {
    logic [C_DIG:0] result;
    logic           timeout;
  } expT;

  logic           clk = 1'b0;
  logic           iRst_n = 1'b1;
  logic           iArm = 1'b0, iStart = 1'b0, iStop = 1'b0, iAbort = 1'b0;
  logic           iReady = 1'b0;
  logic [C_DIG:0] iCoarse;
  logic           oCntRst, oCntCE, oCntStore, oTimeout, oValid, oBusy;
  logic [C_DIG:0] oResult;

  expT            sbQ[$];
  expT            lastExp;
  int             nChecks = 0;
  int             nErrors = 0;

  logic [C_DIG:0] coarseCnt  = '0;
  logic [C_DIG:0] coarseHold = '0;

  coarse_ctrl #(
    .C_DIG       (C_DIG),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .iRst_n    (iRst_n),
    .iArm      (iArm),
    .iStart    (iStart),
    .iStop     (iStop),
    .iAbort    (iAbort),
    .iCoarse   (iCoarse),
    .iReady    (iReady),
    .oCntRst   (oCntRst),
    .oCntCE    (oCntCE),
    .oCntStore (oCntStore),
    .oResult   (oResult),
    .oTimeout  (oTimeout),
    .oValid    (oValid),
    .oBusy     (oBusy)
  );

  always #5 clk = ~clk;

  // Coarse counter model: sync reset, count enable, hold register on store.
  always @(posedge clk) begin
    if (oCntRst)     coarseCnt <= '0;
    else if (oCntCE) coarseCnt <= coarseCnt + 1'b1;
    if (oCntStore)   coarseHold <= coarseCnt;
  end
  assign iCoarse = coarseHold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic armToRun(input bit strayStop);
    iArm = 1'b1;
    tick();
    check("clear_pulse", oCntRst, 1);
    check("clear_busy", oBusy, 1);
    iArm = 1'b0;
    tick();
    check("armed_rst_low", oCntRst, 0);
    check("armed_ce_low", oCntCE, 0);
    if (strayStop) begin
      iStop = 1'b1;
      tick();
      iStop = 1'b0;
      check("stray_stop_ce", oCntCE, 0);
      check("stray_stop_store", oCntStore, 0);
      check("stray_stop_busy", oBusy, 1);
      tick(2);
      check("still_armed", oCntCE, 0);
    end
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("run_ce", oCntCE, 1);
  endtask

  task automatic popCompare();
    expT e;
    for (int i = 0; i < 50 && !oValid; i++) tick();
    check("valid_within_bound", oValid, 1);
    check("sb_size", sbQ.size(), 1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      lastExp = e;
      check("result", oResult, e.result);
      check("timeout_flag", oTimeout, e.timeout);
    end
  endtask

  // Already one RUN cycle in; the stop (if any) lands on RUN cycle runCycles.
  task automatic runToDone(input int runCycles, input bit useStop, input bit expTmo);
    sbQ.push_back('{result: (C_DIG+1)'(runCycles), timeout: expTmo});
    tick(runCycles - 1);
    check("still_run", oCntCE, 1);
    if (useStop) iStop = 1'b1;
    tick();
    iStop = 1'b0;
    check("store_strobe", oCntStore, 1);
    check("store_frozen", oCntCE, 0);
    tick();
    check("capture_not_valid", oValid, 0);
    tick();
    check("valid_latency", oValid, 1);
    popCompare();
  endtask

  task automatic handshake(input int lowCycles, input bit strayArm, input bit holdArm);
    iReady = 1'b0;
    for (int i = 0; i < lowCycles; i++) begin
      iArm = strayArm && (i % 3 == 0);
      tick();
      check("bp_valid", oValid, 1);
      check("bp_result", oResult, lastExp.result);
      check("bp_timeout", oTimeout, lastExp.timeout);
      check("bp_busy", oBusy, 1);
    end
    iArm   = holdArm;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check("hs_valid_drop", oValid, 0);
    check("hs_idle", oBusy, 0);
    check("hs_no_clear", oCntRst, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lastExp = '{result: '0, timeout: 1'b0};
    #1 iRst_n = 1'b0;
    #3;
    check("rst_result", oResult, 0);
    check("rst_valid", oValid, 0);
    check("rst_timeout", oTimeout, 0);
    check("rst_cntrst", oCntRst, 0);
    check("rst_ce", oCntCE, 0);
    check("rst_store", oCntStore, 0);
    check("rst_busy", oBusy, 0);
    @(negedge clk);
    @(negedge clk);
    iRst_n = 1'b1;

    // Normal stop after 37 cycles, with a stray stop while armed.
    armToRun(1'b1);
    runToDone(37, 1'b1, 1'b0);
    handshake(0, 1'b0, 1'b0);

    // No stop: forced by timeout, then 20 cycles of backpressure with stray arms.
    armToRun(1'b0);
    runToDone(TMO, 1'b0, 1'b1);
    handshake(20, 1'b1, 1'b0);

    // Stop coincident with timeout; arm held across handshake for back-to-back.
    armToRun(1'b0);
    runToDone(TMO, 1'b1, 1'b0);
    handshake(0, 1'b0, 1'b1);
    armToRun(1'b0);
    runToDone(12, 1'b1, 1'b0);
    handshake(0, 1'b0, 1'b0);

    // Abort on RUN cycle 15.
    armToRun(1'b0);
    tick(14);
    check("pre_abort_run", oCntCE, 1);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check("abort_idle", oBusy, 0);
    check("abort_rst_pulse", oCntRst, 1);
    check("abort_valid", oValid, 0);
    check("abort_result_held", oResult, lastExp.result);
    tick();
    check("abort_rst_single", oCntRst, 0);
    check("abort_stays_idle", oBusy, 0);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check("idle_abort_ignored", oCntRst, 0);

    // Async reset between edges mid-RUN, then a 5-cycle measurement.
    armToRun(1'b0);
    tick(10);
    #3 iRst_n = 1'b0;
    #1;
    check("arst_result", oResult, 0);
    check("arst_valid", oValid, 0);
    check("arst_timeout", oTimeout, 0);
    check("arst_cntrst", oCntRst, 0);
    check("arst_ce", oCntCE, 0);
    check("arst_store", oCntStore, 0);
    check("arst_busy", oBusy, 0);
    tick();
    check("arst_held_idle", oBusy, 0);
    #2 iRst_n = 1'b1;
    armToRun(1'b0);
    runToDone(5, 1'b1, 1'b0);
    handshake(0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
